rtc_multi_alarm: RTL and testbench
==================================

// Module: rtc_multi_alarm
// PURPOSE
//   24h real-time clock core with internal 1 Hz prescaler and NUM_ALARMS programmable alarms.
//   Adds snooze and auto-timeout alarm handling.
//   Sits between board clock and display/buzzer logic; time and alarms loaded over a simple strobe interface.
// PARAMETERS
//   CLK_HZ        4   clk cycles per second; prescaler terminal count = CLK_HZ-1 (>=2)
//   NUM_ALARMS    4   number of alarm slots (>=1); AW = (NUM_ALARMS>1) ? $clog2(NUM_ALARMS) : 1
//   SNOOZE_S      300 snooze duration in seconds (>=1)
//   RING_S        60  ring auto-timeout in seconds (>=1)
// PORTS
//   clk        in   1   clock
//   rst        in   1   reset, asynchronous, active-high
//   set_time   in   1   1-cycle strobe: load set_hh/set_mm/set_ss
//   set_hh     in   5   hours 0..23
//   set_mm     in   6   minutes 0..59
//   set_ss     in   6   seconds 0..59
//   alm_wr     in   1   1-cycle strobe: write slot alm_idx
//   alm_idx    in   AW  slot index
//   alm_en     in   1   slot enable
//   alm_hh     in   5   alarm hour 0..23
//   alm_mm     in   6   alarm minute 0..59
//   snooze     in   1   snooze request (level sampled each clk)
//   dismiss    in   1   dismiss request (level sampled each clk)
//   hh,mm,ss   out  5,6,6  current time, registered
//   sec_tick   out  1   1-cycle pulse, same edge hh/mm/ss advance
//   alarm      out  1   high while ringing
//   alarm_id   out  AW  slot that triggered the current ring/snooze
//   snoozed    out  1   high while in SNOOZED
// BEHAVIOUR
//   Reset:
//     - all outputs 0, prescaler 0, FSM IDLE.
//     - all slots disabled, 00:00.
//   Prescaler:
//     - counts 0..CLK_HZ-1.
//     - at terminal count, next edge: ss increments, sec_tick=1, prescaler->0.
//   Time advance:
//     - ss 59->0 carries mm; mm 59->0 carries hh; 23:59:59 -> 00:00:00.
//   set_time:
//     - loads time and clears prescaler on the next edge; sec_tick not asserted.
//     - beats a coincident tick.
//     - any field out of range (hh>23, mm>59, ss>59): whole load ignored, time keeps running.
//   alm_wr:
//     - writes the slot on the next edge.
//     - out-of-range hh/mm or alm_idx>=NUM_ALARMS: ignored.
//   Match:
//     - evaluated on the tick edge against the NEW time: enabled slot with hh:mm equal and new ss==0.
//     - set_time landing on hh:mm:00 does not match.
//     - multiple matches: lowest index wins.
//     - alm_wr on the match edge: old slot contents used.
//   FSM IDLE:
//     - match -> RINGING on that same edge: alarm=1, alarm_id=idx, ring counter=0.
//   FSM RINGING:
//     - dismiss -> IDLE.
//     - else snooze -> SNOOZED: alarm=0, snoozed=1, snooze counter=SNOOZE_S.
//     - else ring counter +1 per tick; on the tick reaching RING_S -> IDLE.
//   FSM SNOOZED:
//     - dismiss -> IDLE.
//     - else snooze counter -1 per tick; on the tick reaching 0 -> RINGING, ring counter=0, same alarm_id.
//   Arbitration and isolation:
//     - dismiss beats snooze beats tick-driven transitions in the same cycle.
//     - new matches ignored outside IDLE.
//     - set_time and alm_wr never change FSM state; disabling the active slot does not stop the ring.
//   rst mid-ring/snooze: immediate IDLE, alarm=0, snoozed=0.
//   Latency: every output is registered; state/time changes are visible one edge after the cause.
// TESTING (CLK_HZ=4, NUM_ALARMS=4, SNOOZE_S=3, RING_S=5)
//   1. set_time 23:59:58, run 8 clk -> sec_tick x2; hh:mm:ss 23:59:59 then 00:00:00.
//   2. set_time 25:00:00 at 10:00:00 -> ignored, time continues 10:00:01 after next tick.
//   3. slots 1 and 2 both 07:30 enabled, set_time 07:29:59 -> on tick to 07:30:00 alarm=1, alarm_id=1.
//   4. Ringing, pulse snooze -> alarm=0, snoozed=1.
//      After 3 ticks -> alarm=1 again, alarm_id unchanged; dismiss -> IDLE, all 0.
//   5. Ringing, no input -> alarm drops on the 5th tick after onset; same minute does not retrigger.
//   6. snooze+dismiss same cycle -> IDLE. rst asserted mid-ring -> alarm=0 immediately, slots disabled.

Source files
------------

// File: rtl/rtc_multi_alarm.sv
// 24h real-time clock with 1 Hz prescaler, NUM_ALARMS alarm slots,
// snooze and ring auto-timeout.
module rtc_multi_alarm #(
  parameter int unsigned CLK_HZ     = 4,
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned SNOOZE_S   = 300,
  parameter int unsigned RING_S     = 60,
  localparam int unsigned AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_time,
  input  logic [4:0]    set_hh,
  input  logic [5:0]    set_mm,
  input  logic [5:0]    set_ss,
  input  logic          alm_wr,
  input  logic [AW-1:0] alm_idx,
  input  logic          alm_en,
  input  logic [4:0]    alm_hh,
  input  logic [5:0]    alm_mm,
  input  logic          snooze,
  input  logic          dismiss,
  output logic [4:0]    hh,
  output logic [5:0]    mm,
  output logic [5:0]    ss,
  output logic          sec_tick,
  output logic          alarm,
  output logic [AW-1:0] alarm_id,
  output logic          snoozed
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam int unsigned RW = $clog2(RING_S + 1);
  localparam int unsigned SW = $clog2(SNOOZE_S + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RINGING = 2'd1;
  localparam logic [1:0] SNOOZED = 2'd2;

  logic [PW-1:0] presc;
  logic          tick;
  logic          set_ok;
  logic          alm_ok;
  logic          adv;

  logic [4:0]    hh_inc;
  logic [5:0]    mm_inc;
  logic [5:0]    ss_inc;

  logic          slot_en [NUM_ALARMS];
  logic [4:0]    slot_hh [NUM_ALARMS];
  logic [5:0]    slot_mm [NUM_ALARMS];

  logic          match;
  logic [AW-1:0] match_idx;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [RW-1:0] ring_cnt;
  logic [RW-1:0] ring_n;
  logic [SW-1:0] snz_cnt;
  logic [SW-1:0] snz_n;
  logic [AW-1:0] id_n;

  assign tick   = (presc == PW'(CLK_HZ - 1));
  assign set_ok = set_time && (set_hh <= 5'd23) && (set_mm <= 6'd59) && (set_ss <= 6'd59);
  assign alm_ok = alm_wr && (alm_hh <= 5'd23) && (alm_mm <= 6'd59) &&
                  (32'(alm_idx) < NUM_ALARMS);
  // A valid time load suppresses the coincident second advance.
  assign adv    = tick && !set_ok;

  // Time one second ahead of the current time, with carries.
  always_comb begin
    ss_inc = ss + 6'd1;
    mm_inc = mm;
    hh_inc = hh;
    if (ss == 6'd59) begin
      ss_inc = 6'd0;
      mm_inc = mm + 6'd1;
      if (mm == 6'd59) begin
        mm_inc = 6'd0;
        hh_inc = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
      end
    end
  end

  // Alarm match against the time about to be entered; lowest index wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
      if (adv && (ss_inc == 6'd0) && slot_en[i] &&
          (slot_hh[i] == hh_inc) && (slot_mm[i] == mm_inc)) begin
        match     = 1'b1;
        match_idx = AW'(i);
      end
    end
  end

  // Prescaler and time-of-day registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      hh       <= '0;
      mm       <= '0;
      ss       <= '0;
      sec_tick <= 1'b0;
    end else if (set_ok) begin
      presc    <= '0;
      hh       <= set_hh;
      mm       <= set_mm;
      ss       <= set_ss;
      sec_tick <= 1'b0;
    end else if (tick) begin
      presc    <= '0;
      hh       <= hh_inc;
      mm       <= mm_inc;
      ss       <= ss_inc;
      sec_tick <= 1'b1;
    end else begin
      presc    <= presc + PW'(1);
      sec_tick <= 1'b0;
    end
  end

  // Alarm slot storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        slot_en[i] <= 1'b0;
        slot_hh[i] <= '0;
        slot_mm[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (alm_ok && (alm_idx == AW'(i))) begin
          slot_en[i] <= alm_en;
          slot_hh[i] <= alm_hh;
          slot_mm[i] <= alm_mm;
        end
      end
    end
  end

  // Alarm FSM next state: dismiss beats snooze beats per-second timing.
  always_comb begin
    state_n = state;
    ring_n  = ring_cnt;
    snz_n   = snz_cnt;
    id_n    = alarm_id;
    case (state)
      IDLE: begin
        if (match) begin
          state_n = RINGING;
          ring_n  = '0;
          id_n    = match_idx;
        end
      end
      RINGING: begin
        if (dismiss) begin
          state_n = IDLE;
        end else if (snooze) begin
          state_n = SNOOZED;
          snz_n   = SW'(SNOOZE_S);
        end else if (adv) begin
          ring_n = ring_cnt + RW'(1);
          if (ring_n == RW'(RING_S)) state_n = IDLE;
        end
      end
      SNOOZED: begin
        if (dismiss) begin
          state_n = IDLE;
        end else if (adv) begin
          snz_n = snz_cnt - SW'(1);
          if (snz_cnt == SW'(1)) begin
            state_n = RINGING;
            ring_n  = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) id_n = '0;
  end

  // FSM state and registered alarm outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      alarm_id <= '0;
      alarm    <= 1'b0;
      snoozed  <= 1'b0;
    end else begin
      state    <= state_n;
      ring_cnt <= ring_n;
      snz_cnt  <= snz_n;
      alarm_id <= id_n;
      alarm    <= (state_n == RINGING);
      snoozed  <= (state_n == SNOOZED);
    end
  end

endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Directed bench for rtc_multi_alarm (CLK_HZ=4, NUM_ALARMS=4, SNOOZE_S=3, RING_S=5).
module tb_rtc_multi_alarm;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_time;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       alm_wr;
  logic [1:0] alm_idx;
  logic       alm_en;
  logic [4:0] alm_hh;
  logic [5:0] alm_mm;
  logic       snooze;
  logic       dismiss;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       sec_tick;
  logic       alarm;
  logic [1:0] alarm_id;
  logic       snoozed;

  int tests = 0;
  int fails = 0;

  rtc_multi_alarm #(
    .CLK_HZ(4), .NUM_ALARMS(4), .SNOOZE_S(3), .RING_S(5)
  ) dut (
    .clk(clk), .rst(rst),
    .set_time(set_time), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alm_wr(alm_wr), .alm_idx(alm_idx), .alm_en(alm_en),
    .alm_hh(alm_hh), .alm_mm(alm_mm),
    .snooze(snooze), .dismiss(dismiss),
    .hh(hh), .mm(mm), .ss(ss), .sec_tick(sec_tick),
    .alarm(alarm), .alarm_id(alarm_id), .snoozed(snoozed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int now_t();
    return int'(hh) * 10000 + int'(mm) * 100 + int'(ss);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_t(input int h, input int m, input int s);
    set_time = 1'b1;
    set_hh   = 5'(h);
    set_mm   = 6'(m);
    set_ss   = 6'(s);
    @(negedge clk);
    set_time = 1'b0;
  endtask

  task automatic wr_slot(input int idx, input bit en, input int h, input int m);
    alm_wr  = 1'b1;
    alm_idx = 2'(idx);
    alm_en  = en;
    alm_hh  = 5'(h);
    alm_mm  = 6'(m);
    @(negedge clk);
    alm_wr  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; set_time = 1'b0; set_hh = '0; set_mm = '0; set_ss = '0;
    alm_wr = 1'b0; alm_idx = '0; alm_en = 1'b0; alm_hh = '0; alm_mm = '0;
    snooze = 1'b0; dismiss = 1'b0;
    cyc(2);
    chk("rst_time", now_t(), 0);
    chk("rst_tick", int'(sec_tick), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_id", int'(alarm_id), 0);
    chk("rst_snoozed", int'(snoozed), 0);
    rst = 1'b0;

    // 1: midnight rollover
    set_t(23, 59, 58);
    chk("t1_load", now_t(), 235958);
    chk("t1_load_tick", int'(sec_tick), 0);
    cyc(3);
    chk("t1_pre_tick", int'(sec_tick), 0);
    chk("t1_pre_time", now_t(), 235958);
    cyc(1);
    chk("t1_tick1", int'(sec_tick), 1);
    chk("t1_time1", now_t(), 235959);
    cyc(1);
    chk("t1_tick_pulse", int'(sec_tick), 0);
    cyc(3);
    chk("t1_tick2", int'(sec_tick), 1);
    chk("t1_time2", now_t(), 0);

    // 2: invalid load ignored; valid load beats coincident tick
    set_t(10, 0, 0);
    set_t(25, 0, 0);
    chk("t2_bad_load", now_t(), 100000);
    cyc(2);
    chk("t2_hold", now_t(), 100000);
    cyc(1);
    chk("t2_run", now_t(), 100001);
    chk("t2_run_tick", int'(sec_tick), 1);
    cyc(3);
    set_t(12, 0, 0);
    chk("t2_beat_time", now_t(), 120000);
    chk("t2_beat_tick", int'(sec_tick), 0);
    cyc(4);
    chk("t2_after_beat", now_t(), 120001);

    // 3: two slots match, lowest index wins; invalid write leaves slot 3 intact
    wr_slot(1, 1'b1, 7, 30);
    wr_slot(2, 1'b1, 7, 30);
    wr_slot(3, 1'b1, 8, 0);
    wr_slot(3, 1'b0, 24, 0);
    set_t(7, 29, 59);
    cyc(3);
    chk("t3_pre_alarm", int'(alarm), 0);
    cyc(1);
    chk("t3_time", now_t(), 73000);
    chk("t3_alarm", int'(alarm), 1);
    chk("t3_id", int'(alarm_id), 1);
    chk("t3_snoozed", int'(snoozed), 0);

    // 4: snooze for 3 seconds, ring again, dismiss
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    chk("t4_snz_alarm", int'(alarm), 0);
    chk("t4_snz_flag", int'(snoozed), 1);
    chk("t4_snz_id", int'(alarm_id), 1);
    cyc(10);
    chk("t4_still_snz", int'(snoozed), 1);
    chk("t4_still_quiet", int'(alarm), 0);
    cyc(1);
    chk("t4_reRing", int'(alarm), 1);
    chk("t4_reRing_snz", int'(snoozed), 0);
    chk("t4_reRing_id", int'(alarm_id), 1);
    dismiss = 1'b1;
    @(negedge clk);
    dismiss = 1'b0;
    chk("t4_dis_alarm", int'(alarm), 0);
    chk("t4_dis_snz", int'(snoozed), 0);
    chk("t4_dis_id", int'(alarm_id), 0);

    // 5: auto-timeout after RING_S ticks; no retrigger in same minute
    set_t(7, 59, 59);
    cyc(4);
    chk("t5_time", now_t(), 80000);
    chk("t5_alarm", int'(alarm), 1);
    chk("t5_id", int'(alarm_id), 3);
    cyc(16);
    chk("t5_4th_tick", int'(alarm), 1);
    cyc(4);
    chk("t5_5th_time", now_t(), 80005);
    chk("t5_timeout", int'(alarm), 0);
    cyc(4);
    chk("t5_no_retrig", int'(alarm), 0);
    set_t(8, 0, 0);
    chk("t5_load_no_match", int'(alarm), 0);
    cyc(4);
    chk("t5_load_time", now_t(), 80001);
    chk("t5_load_quiet", int'(alarm), 0);

    // 6: dismiss beats snooze; disabling active slot keeps ring; async reset
    set_t(7, 29, 59);
    cyc(4);
    chk("t6_ring", int'(alarm), 1);
    snooze  = 1'b1;
    dismiss = 1'b1;
    @(negedge clk);
    snooze  = 1'b0;
    dismiss = 1'b0;
    chk("t6_both_alarm", int'(alarm), 0);
    chk("t6_both_snz", int'(snoozed), 0);
    set_t(7, 29, 59);
    cyc(4);
    chk("t6_ring2", int'(alarm), 1);
    wr_slot(1, 1'b0, 7, 30);
    chk("t6_disable_keeps", int'(alarm), 1);
    chk("t6_disable_id", int'(alarm_id), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_alarm", int'(alarm), 0);
    chk("t6_rst_snz", int'(snoozed), 0);
    chk("t6_rst_time", now_t(), 0);
    @(negedge clk);
    rst = 1'b0;
    set_t(7, 29, 59);
    cyc(4);
    chk("t6_post_rst_time", now_t(), 73000);
    chk("t6_slots_cleared", int'(alarm), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
